alu: RTL and testbench
======================

// Module: alu
// PURPOSE
//  Parameterised ALU of the microprocessor datapath. Executes one of eight
//  operations on operands a/b (add and subtract take carry-in C_in).
//  Registers the result plus PSW-style flags P, Z, S, C, OV, one cycle later.
//  Sits between the register file/accumulator and the PSW/write-back path.
// PARAMETERS
//  ALU_rozm_data  8  data width W in bits (>=2); a, b and out are all W wide
// PORTS
//  clk     in   1  single clock; all state on rising edge
//  rst_n   in   1  reset: synchronous, active-low
//  a       in   W  operand A
//  b       in   W  operand B
//  alu_op  in   3  operation select (encoding below)
//  C_in    in   1  carry/borrow in; used by ADD/SUB only
//  out     out  W  registered result
//  P       out  1  parity of out: XOR-reduce (1 = odd number of ones)
//  Z       out  1  1 when out == 0
//  S       out  1  sign = out[W-1]
//  C       out  1  carry (ADD) / borrow (SUB); 0 for other ops
//  OV      out  1  signed two's-complement overflow (ADD/SUB); 0 otherwise
// BEHAVIOUR
//  - Reset: on posedge clk with rst_n==0, out, P, Z, S, C and OV all go to 0.
//    Reset wins over any operation in the same cycle.
//  - Latency: 1 cycle. Inputs are sampled at posedge k; results are visible
//    after that edge. No handshake; a new op is accepted every cycle.
//  - Opcodes (3'd):
//      0 MOVB  out = b
//      1 AND   out = a & b
//      2 OR    out = a | b
//      3 XOR   out = a ^ b
//      4 ADD   {C,out} = a + b + C_in   (W+1-bit sum)
//      5 SUB   out = a - b - C_in; C = 1 iff a < b + C_in (unsigned borrow)
//      6 NOTB  out = ~b
//      7 MOVA  out = a
//  - OV for ADD: a[W-1]==b[W-1] and out[W-1]!=a[W-1].
//  - OV for SUB: a[W-1]!=b[W-1] and out[W-1]!=a[W-1].
//  - P, Z and S are derived from the new result for every opcode.
//  - C and OV are forced to 0 for opcodes 0-3 and 6-7.
//  - Wrap-around: results are truncated modulo 2^W; the carry goes only to C.
//  - All next-state logic is combinational (no latches); one registered stage.
// STRUCTURE
//  - Package alu_pkg holds typedef enum logic[2:0] alu_op_e (values above)
//    and the default width constant.
//  - One sub-module, alu_flag_gen: combinational, W-bit result in -> P, Z, S.
//  - Main block: opcode mux, (W+1)-bit adder/subtractor, OV logic, output
//    registers.
// TESTING
//  1 Reset: rst_n=0 for 2 cycles with any inputs -> out=0, P=Z=S=C=OV=0.
//  2 ADD: a=8'h7F, b=8'h01, C_in=0 -> out=8'h80, OV=1, C=0, S=1, P=1.
//    a=8'h7F, b=8'hC0 -> out=8'h3F, C=1, OV=0.
//    a=8'hFF, b=8'hFF -> out=8'hFE, C=1, OV=0.
//  3 ADD with carry: a=5, b=4, C_in=1 -> out=10, C=0.
//    a=b=0, C_in=0 -> out=0, Z=1.
//  4 SUB: a=5, b=4 -> out=1, C=0, Z=0.
//    a=4, b=5 -> out=8'hFF, C=1, S=1, P=0.
//    a=8'h80, b=1 -> out=8'h7F, OV=1.
//  5 MOVB flags: b=8'hAA -> P=0; b=8'hAB -> P=1; b=8'h80 -> S=1;
//    b=8'h60 -> S=0; b=8'h8C -> Z=0; b=0 -> Z=1; C=OV=0 throughout.
//  6 Logic/latency: a=8'hAA, b=8'h0F: ops 1,2,3,6,7 give
//    8'h0A, 8'hAF, 8'hA5, 8'hF0, 8'hAA. Each value appears exactly one
//    cycle after its inputs; rst_n=0 mid-stream clears all outputs on the
//    next edge.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encoding and the default datapath width.
package alu_pkg;

  localparam int ALU_W_DEFAULT = 8;

  typedef enum logic [2:0] {
    OP_MOVB = 3'd0,
    OP_AND  = 3'd1,
    OP_OR   = 3'd2,
    OP_XOR  = 3'd3,
    OP_ADD  = 3'd4,
    OP_SUB  = 3'd5,
    OP_NOTB = 3'd6,
    OP_MOVA = 3'd7
  } alu_op_e;

endpackage

// File: rtl/alu_flag_gen.sv
// Result-derived PSW flags: parity, zero, sign. Purely combinational.
module alu_flag_gen #(
  parameter int W = 8
) (
  input  logic [W-1:0] i_res,
  output logic         o_p,
  output logic         o_z,
  output logic         o_s
);

  assign o_p = ^i_res;
  assign o_z = (i_res == '0);
  assign o_s = i_res[W-1];

endmodule

// File: rtl/alu.sv
// Eight-op ALU with registered result and P/Z/S/C/OV flags.
// One-cycle latency, a new op every cycle, no backpressure.
module alu
  import alu_pkg::*;
#(
  parameter int ALU_rozm_data = ALU_W_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [ALU_rozm_data-1:0] a,
  input  logic [ALU_rozm_data-1:0] b,
  input  logic [2:0]               alu_op,
  input  logic                     C_in,
  output logic [ALU_rozm_data-1:0] out,
  output logic                     P,
  output logic                     Z,
  output logic                     S,
  output logic                     C,
  output logic                     OV
);

  localparam int W = ALU_rozm_data;

  logic [W:0]   w_cin_ext;
  logic [W:0]   w_sum;
  logic [W:0]   w_diff;
  logic [W-1:0] w_res;
  logic         w_c;
  logic         w_ov;
  logic         w_p;
  logic         w_z;
  logic         w_s;

  logic [W-1:0] r_out;
  logic         r_p;
  logic         r_z;
  logic         r_s;
  logic         r_c;
  logic         r_ov;

  // The extra top bit of the W+1-bit difference is the unsigned borrow.
  assign w_cin_ext = {{W{1'b0}}, C_in};
  assign w_sum     = {1'b0, a} + {1'b0, b} + w_cin_ext;
  assign w_diff    = {1'b0, a} - {1'b0, b} - w_cin_ext;

  always_comb begin
    w_res = b;
    w_c   = 1'b0;
    w_ov  = 1'b0;
    case (alu_op_e'(alu_op))
      OP_MOVB: w_res = b;
      OP_AND:  w_res = a & b;
      OP_OR:   w_res = a | b;
      OP_XOR:  w_res = a ^ b;
      OP_ADD: begin
        w_res = w_sum[W-1:0];
        w_c   = w_sum[W];
        w_ov  = (a[W-1] == b[W-1]) && (w_sum[W-1] != a[W-1]);
      end
      OP_SUB: begin
        w_res = w_diff[W-1:0];
        w_c   = w_diff[W];
        w_ov  = (a[W-1] != b[W-1]) && (w_diff[W-1] != a[W-1]);
      end
      OP_NOTB: w_res = ~b;
      OP_MOVA: w_res = a;
      default: w_res = b;
    endcase
  end

  alu_flag_gen #(
    .W (W)
  ) u_flag_gen (
    .i_res (w_res),
    .o_p   (w_p),
    .o_z   (w_z),
    .o_s   (w_s)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out <= '0;
      r_p   <= 1'b0;
      r_z   <= 1'b0;
      r_s   <= 1'b0;
      r_c   <= 1'b0;
      r_ov  <= 1'b0;
    end else begin
      r_out <= w_res;
      r_p   <= w_p;
      r_z   <= w_z;
      r_s   <= w_s;
      r_c   <= w_c;
      r_ov  <= w_ov;
    end
  end

  assign out = r_out;
  assign P   = r_p;
  assign Z   = r_z;
  assign S   = r_s;
  assign C   = r_c;
  assign OV  = r_ov;

endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for alu: driver pushes model predictions, monitor pops one per cycle.
module tb_alu;

  localparam int W  = 8;
  localparam int M  = 2 ** W;
  localparam int HI = 2 ** (W - 1) - 1;
  localparam int LO = -(2 ** (W - 1));

  typedef struct {
    int         id;
    logic [7:0] out;
    logic [4:0] flags; // {P,Z,S,C,OV}
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [2:0]   alu_op;
  logic         C_in;
  logic [W-1:0] out;
  logic         P, Z, S, C, OV;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;
  int   next_id  = 0;

  alu #(.ALU_rozm_data(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .a      (a),
    .b      (b),
    .alu_op (alu_op),
    .C_in   (C_in),
    .out    (out),
    .P      (P),
    .Z      (Z),
    .S      (S),
    .C      (C),
    .OV     (OV)
  );

  always #5 clk = ~clk;

  function automatic int to_signed(input int u);
    return (u > HI) ? u - M : u;
  endfunction

  // Reference: plain integer arithmetic over the opcode table.
  function automatic exp_t model(input logic rst, input int ua, input int ub,
                                 input int op, input int cin);
    exp_t e;
    int r, full, sv, ones;
    logic cy, ov;
    r = 0; cy = 1'b0; ov = 1'b0;
    if (rst) begin
      e.out = '0; e.flags = '0; e.id = 0;
      return e;
    end
    case (op)
      0: r = ub;
      1: r = ua & ub;
      2: r = ua | ub;
      3: r = ua ^ ub;
      4: begin
        full = ua + ub + cin;
        r    = full % M;
        cy   = (full >= M);
        sv   = to_signed(ua) + to_signed(ub) + cin;
        ov   = (sv > HI) || (sv < LO);
      end
      5: begin
        full = ua - ub - cin;
        r    = (full + M) % M;
        cy   = (ua < ub + cin);
        sv   = to_signed(ua) - to_signed(ub) - cin;
        ov   = (sv > HI) || (sv < LO);
      end
      6: r = (M - 1) - ub;
      default: r = ua;
    endcase
    ones = 0;
    for (int i = 0; i < W; i++) ones += (r >> i) & 1;
    e.out   = r[7:0];
    e.flags = {(ones % 2) == 1, r == 0, r >= M / 2, cy, ov};
    e.id    = 0;
    return e;
  endfunction

  // Apply inputs for the next rising edge and predict what it will register.
  task automatic issue(input logic rst, input int ua, input int ub, input int op, input int cin);
    exp_t e;
    rst_n  = ~rst;
    a      = ua[W-1:0];
    b      = ub[W-1:0];
    alu_op = op[2:0];
    C_in   = cin[0];
    e      = model(rst, ua, ub, op, cin);
    e.id   = next_id;
    next_id++;
    q.push_back(e);
    @(negedge clk);
  endtask

  // Monitor: every edge registers exactly one issued op, so pop one per cycle.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if (out !== e.out) begin
          failures++;
          $display("FAIL out id=%0d got=%h exp=%h", e.id, out, e.out);
        end
        checks++;
        if ({P, Z, S, C, OV} !== e.flags) begin
          failures++;
          $display("FAIL flags id=%0d got PZSCOV=%b exp=%b", e.id, {P, Z, S, C, OV}, e.flags);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    // Reset held for two cycles with arbitrary inputs.
    issue(1, 8'h5A, 8'hC3, 4, 1);
    issue(1, 8'hFF, 8'hFF, 5, 1);
    // ADD
    issue(0, 8'h7F, 8'h01, 4, 0);
    issue(0, 8'h7F, 8'hC0, 4, 0);
    issue(0, 8'hFF, 8'hFF, 4, 0);
    issue(0, 5, 4, 4, 1);
    issue(0, 0, 0, 4, 0);
    // SUB
    issue(0, 5, 4, 5, 0);
    issue(0, 4, 5, 5, 0);
    issue(0, 8'h80, 1, 5, 0);
    issue(0, 8'h80, 0, 5, 1);
    issue(0, 0, 0, 5, 1);
    // MOVB flags
    issue(0, 8'h11, 8'hAA, 0, 1);
    issue(0, 8'h22, 8'hAB, 0, 0);
    issue(0, 8'h33, 8'h80, 0, 1);
    issue(0, 8'h44, 8'h60, 0, 0);
    issue(0, 8'h55, 8'h8C, 0, 1);
    issue(0, 8'h66, 8'h00, 0, 0);
    // Logic ops back-to-back, then a mid-stream reset.
    issue(0, 8'hAA, 8'h0F, 1, 1);
    issue(0, 8'hAA, 8'h0F, 2, 0);
    issue(0, 8'hAA, 8'h0F, 3, 1);
    issue(0, 8'hAA, 8'h0F, 6, 0);
    issue(0, 8'hAA, 8'h0F, 7, 1);
    issue(1, 8'hAA, 8'h0F, 4, 1);
    issue(0, 8'hAA, 8'h0F, 7, 0);
    // Randomized stream with occasional resets.
    for (int n = 0; n < 400; n++) begin
      issue($urandom_range(0, 24) == 0, $urandom_range(0, M - 1), $urandom_range(0, M - 1),
            $urandom_range(0, 7), $urandom_range(0, 1));
    end
    issue(0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain got=%0d pending exp=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
